// File: rtl/expansion_pkg.sv
// Shared types and sizing helpers for the expansion block and its lane sub-module.
// Lane counts and field widths are derived from N (word width) and M (lane width).
package expansion_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_N = 8;
  localparam int DEF_M = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < value; i++) begin
      r = i + 1;
    end
    return r;
  endfunction

  // Reduced field carries W+1 bits, with W = M/2.
  function automatic int field_width(input int m);
    return (m / 2) + 1;
  endfunction

  function automatic int lane_count(input int n, input int m);
    return n / m;
  endfunction

  // Lane index register never collapses to zero bits, even for a single lane.
  function automatic int idx_width(input int n, input int m);
    return (clog2(lane_count(n, m)) < 1) ? 1 : clog2(lane_count(n, m));
  endfunction

endpackage

// File: rtl/lane_expand.sv
// Zero-extends one reduced (M/2+1)-bit field to a full M-bit lane.
module lane_expand
  import expansion_pkg::*;
#(
  parameter int M  = DEF_M,
  localparam int FW = field_width(M)
) (
  input  logic [FW-1:0] field_i,
  output logic [M-1:0]  lane_o
);

  // FW <= M for every even M >= 2, so the cast only ever pads with zeros.
  assign lane_o = M'(field_i);

endmodule

// File: rtl/expansion.sv
// Collects L reduced fields (lane 0 first) and presents the reassembled N-bit word.
// Optional EXPANSION_CNT_EN adds a 16-bit wrapping count of delivered words.
module expansion
  import expansion_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M,
  localparam int FW = field_width(M),
  localparam int L  = lane_count(N, M),
  localparam int IW = idx_width(N, M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] in_field,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out
`ifdef EXPANSION_CNT_EN
  ,
  output logic [15:0]   word_cnt
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [L-1:0][M-1:0]    lanes_q, lanes_d;
  logic [M-1:0]           lane_wr;
  logic                   accept;

  lane_expand #(.M(M)) u_lane_expand (
    .field_i (in_field),
    .lane_o  (lane_wr)
  );

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  // Lanes are registers; lane 0 sits in the LSBs.
  assign out       = lanes_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < L; i++) begin
            if (idx_q == IW'(i)) begin
              lanes_d[i] = lane_wr;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

`ifdef EXPANSION_CNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (out_valid && out_ready) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_expansion.sv
// Scoreboard bench for expansion: an N=8/M=4 instance and an N=16/M=4 instance.
// Expected words are queued as fields are driven and compared when each word is handed off.
module tb_expansion;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_field;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [2:0]  w_in_field;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_out;

`ifdef EXPANSION_CNT_EN
  logic [15:0] word_cnt;
  logic [15:0] w_word_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_w_q[$];

  expansion #(.N(8), .M(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_field  (in_field),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef EXPANSION_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  expansion #(.N(16), .M(4)) u_wide (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_field  (w_in_field),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out       (w_out)
`ifdef EXPANSION_CNT_EN
    ,
    .word_cnt  (w_word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: compare whenever a word is handed off downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", {24'd0, out}, 32'hDEAD);
      else check("word", {24'd0, out}, {24'd0, exp_q.pop_front()});
    end
    if (!rst && w_out_valid && w_out_ready) begin
      if (exp_w_q.size() == 0) check("unexpected_wide", {16'd0, w_out}, 32'hDEAD);
      else check("wide_word", {16'd0, w_out}, {16'd0, exp_w_q.pop_front()});
    end
  end

  // Present a field, wait for the handshake (bounded), then leave a gap.
  task automatic send_field(input logic [2:0] f, input int gap);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_field = f;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_wide(input logic [2:0] f);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 0;
    w_in_valid = 1'b1;
    w_in_field = f;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = w_in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) check("wide_accept_timeout", 32'd0, 32'd1);
    w_in_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f0, f1;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_field   = '0;
    out_ready  = 1'b1;
    w_in_valid = 1'b0;
    w_in_field = '0;
    w_out_ready = 1'b1;
    repeat (2) cycle();
    @(negedge clk);
    check("rst_out", {24'd0, out}, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef EXPANSION_CNT_EN
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic word, back-to-back fields, single-cycle out_valid.
    exp_q.push_back(8'h35);
    send_field(3'b101, 0);
    @(negedge clk);
    check("basic_not_yet_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    send_field(3'b011, 0);
    @(negedge clk);
    check("basic_valid_rise", {31'd0, out_valid}, 32'd1);
    check("basic_hold_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    @(negedge clk);
    check("basic_valid_fall", {31'd0, out_valid}, 32'd0);
    cycle();

    // Backpressure: word held, field presented in HOLD becomes lane 0 of next word.
    out_ready = 1'b0;
    exp_q.push_back(8'h35);
    send_field(3'b101, 0);
    send_field(3'b011, 0);
    in_valid = 1'b1;
    in_field = 3'b110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out", {24'd0, out}, 32'h35);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      cycle();
    end
    out_ready = 1'b1;
    exp_q.push_back(8'h16);
    send_field(3'b110, 0);
    send_field(3'b001, 0);
    cycle();

    // Bubbles between fields.
    exp_q.push_back(8'h35);
    send_field(3'b101, 2);
    send_field(3'b011, 2);

    // Reset mid-word discards the partial word.
    send_field(3'b111, 0);
    pulse_reset();
    exp_q.push_back(8'h21);
    send_field(3'b001, 0);
    send_field(3'b010, 0);
    cycle();

    // Reset in HOLD drops the pending word.
    out_ready = 1'b0;
    send_field(3'b100, 0);
    send_field(3'b100, 0);
    @(negedge clk);
    check("hold_pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("hold_rst_valid", {31'd0, out_valid}, 32'd0);
    check("hold_rst_out", {24'd0, out}, 32'h0);
    check("hold_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    cycle();

    // Random fields with random gaps.
    for (int i = 0; i < 6; i++) begin
      f0 = 3'($urandom_range(0, 7));
      f1 = 3'($urandom_range(0, 7));
      exp_q.push_back({1'b0, f1, 1'b0, f0});
      send_field(f0, int'($urandom_range(0, 1)));
      send_field(f1, int'($urandom_range(0, 1)));
    end
    cycle();

    // Wide instance: four lanes.
    exp_w_q.push_back(16'h2507);
    send_wide(3'd7);
    send_wide(3'd0);
    send_wide(3'd5);
    send_wide(3'd2);
    cycle();

`ifdef EXPANSION_CNT_EN
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h35);
      send_field(3'b101, 0);
      send_field(3'b011, 0);
    end
    cycle();
    @(negedge clk);
    check("cnt_three", {16'd0, word_cnt}, 32'd3);
    @(posedge clk);
    #1;
    force u_dut.word_cnt_q = 16'hFFFF;
    cycle();
    release u_dut.word_cnt_q;
    @(negedge clk);
    check("cnt_forced", {16'd0, word_cnt}, 32'hFFFF);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h35);
    send_field(3'b101, 0);
    send_field(3'b011, 0);
    cycle();
    @(negedge clk);
    check("cnt_wrap", {16'd0, word_cnt}, 32'd0);
    @(posedge clk);
    #1;
`endif

    repeat (4) cycle();
    check("sb_drained", exp_q.size(), 32'd0);
    check("sb_wide_drained", exp_w_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
